// File: rtl/dmem_access_ctrl.sv
// Sequences LDUR/STUR data-memory accesses: effective address and alignment check,
// a valid/ready memory request, a bounded wait for load data, and a one-cycle response.
module dmem_access_ctrl #(
    parameter int OFFS_W   = 9,
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_load,
    input  logic [1:0]        req_size,
    input  logic [DATA_W-1:0] req_base,
    input  logic [OFFS_W-1:0] req_daddr9,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_size,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              stall
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] ea_q, ea_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              is_load_q, is_load_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [DATA_W-1:0] ea;
    logic [2:0]        align_mask;
    logic              misaligned;
    logic [DATA_W-1:0] rdata_masked;

    assign ea = req_base + {{(DATA_W-OFFS_W){req_daddr9[OFFS_W-1]}}, req_daddr9};

    always_comb begin
        align_mask = 3'b000;
        case (req_size)
            2'b00: align_mask = 3'b000;
            2'b01: align_mask = 3'b001;
            2'b10: align_mask = 3'b011;
            2'b11: align_mask = 3'b111;
            default: align_mask = 3'b000;
        endcase
    end

    assign misaligned = |(ea[2:0] & align_mask);

    // Load data is zero-extended to the latched access size.
    always_comb begin
        rdata_masked = mem_rdata;
        case (size_q)
            2'b00: rdata_masked = {{(DATA_W-8){1'b0}},  mem_rdata[7:0]};
            2'b01: rdata_masked = {{(DATA_W-16){1'b0}}, mem_rdata[15:0]};
            2'b10: rdata_masked = {{(DATA_W-32){1'b0}}, mem_rdata[31:0]};
            default: rdata_masked = mem_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ea_d      = ea_q;
        wdata_d   = wdata_q;
        size_d    = size_q;
        is_load_d = is_load_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    ea_d      = ea;
                    wdata_d   = req_wdata;
                    size_d    = req_size;
                    is_load_d = req_is_load;
                    rdata_d   = '0;
                    err_d     = misaligned;
                    state_d   = misaligned ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_ready) begin
                    cnt_d   = '0;
                    state_d = is_load_q ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // Data arriving on the timeout cycle still counts as success.
                if (mem_rvalid) begin
                    rdata_d = rdata_masked;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == WAIT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ea_q      <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            is_load_q <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            ea_q      <= ea_d;
            wdata_q   <= wdata_d;
            size_q    <= size_d;
            is_load_q <= is_load_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign stall      = (state_q != S_IDLE);
    assign mem_valid  = (state_q == S_ISSUE);
    assign mem_write  = mem_valid & ~is_load_q;
    assign mem_addr   = mem_valid ? ea_q    : '0;
    assign mem_wdata  = mem_valid ? wdata_q : '0;
    assign mem_size   = mem_valid ? size_q  : 2'b00;
    assign resp_valid = (state_q == S_RESP);
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = resp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: store, load, misalignment, backpressure,
// timeout, address wrap and mid-transaction reset, all with hand-computed expectations.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_load;
    logic [1:0]  req_size;
    logic [63:0] req_base;
    logic [8:0]  req_daddr9;
    logic [63:0] req_wdata;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_write;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        resp_valid;
    logic        resp_err;
    logic [63:0] resp_rdata;
    logic        stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.OFFS_W(9), .DATA_W(64), .MAX_WAIT(15)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_load(req_is_load),
        .req_size(req_size), .req_base(req_base), .req_daddr9(req_daddr9),
        .req_wdata(req_wdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .stall(stall)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic ld, input logic [1:0] sz, input logic [63:0] base,
                           input logic [8:0] d9, input logic [63:0] wd);
        req_valid   = 1'b1;
        req_is_load = ld;
        req_size    = sz;
        req_base    = base;
        req_daddr9  = d9;
        req_wdata   = wd;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_is_load = 1'b0; req_size = 2'b00;
        req_base = '0; req_daddr9 = '0; req_wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);

        // 1) aligned dword store with negative offset
        present(1'b0, 2'b11, 64'h1000, 9'h1F8, 64'h1122_3344_5566_7788);
        mem_ready = 1'b1;
        tick(); req_valid = 1'b0;
        check("st_mem_valid", 64'(mem_valid), 64'd1);
        check("st_mem_addr", mem_addr, 64'hFF8);
        check("st_mem_write", 64'(mem_write), 64'd1);
        check("st_mem_wdata", mem_wdata, 64'h1122_3344_5566_7788);
        check("st_stall", 64'(stall), 64'd1);
        check("st_resp_early", 64'(resp_valid), 64'd0);
        tick();
        check("st_resp_valid", 64'(resp_valid), 64'd1);
        check("st_resp_err", 64'(resp_err), 64'd0);
        check("st_mem_valid_off", 64'(mem_valid), 64'd0);
        tick();
        check("st_resp_pulse", 64'(resp_valid), 64'd0);
        check("st_idle", 64'(req_ready), 64'd1);
        $display("txn store addr=0xff8 done");

        // 2) byte load, data one cycle after handshake
        present(1'b1, 2'b00, 64'h2000, 9'h010, 64'h0);
        tick(); req_valid = 1'b0;
        check("ldb_mem_addr", mem_addr, 64'h2010);
        check("ldb_mem_write", 64'(mem_write), 64'd0);
        check("ldb_mem_size", 64'(mem_size), 64'd0);
        tick();
        check("ldb_wait_mem_valid", 64'(mem_valid), 64'd0);
        check("ldb_wait_resp", 64'(resp_valid), 64'd0);
        mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
        tick(); mem_rvalid = 1'b0;
        check("ldb_resp_valid", 64'(resp_valid), 64'd1);
        check("ldb_resp_rdata", resp_rdata, 64'h0D);
        check("ldb_resp_err", 64'(resp_err), 64'd0);
        tick();
        check("ldb_rdata_zero", resp_rdata, 64'd0);
        $display("txn load byte addr=0x2010 done");

        // word load: checks size masking at 32 bits
        present(1'b1, 2'b10, 64'h2000, 9'h004, 64'h0);
        tick(); req_valid = 1'b0;
        check("ldw_mem_addr", mem_addr, 64'h2004);
        tick();
        mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
        tick(); mem_rvalid = 1'b0;
        check("ldw_resp_rdata", resp_rdata, 64'hCAFE_F00D);
        tick();
        $display("txn load word addr=0x2004 done");

        // 3) misaligned dword
        present(1'b1, 2'b11, 64'h1001, 9'h000, 64'h0);
        tick(); req_valid = 1'b0;
        check("mis_mem_valid", 64'(mem_valid), 64'd0);
        check("mis_resp_valid", 64'(resp_valid), 64'd1);
        check("mis_resp_err", 64'(resp_err), 64'd1);
        check("mis_resp_rdata", resp_rdata, 64'd0);
        tick();
        check("mis_idle", 64'(req_ready), 64'd1);
        $display("txn misaligned dword addr=0x1001 done");

        // misaligned half by odd offset only
        present(1'b0, 2'b01, 64'h3000, 9'h003, 64'h0);
        tick(); req_valid = 1'b0;
        check("mish_resp_err", 64'(resp_err), 64'd1);
        tick();
        $display("txn misaligned half addr=0x3003 done");

        // 4) backpressure: memory not ready for 5 cycles
        mem_ready = 1'b0;
        present(1'b0, 2'b10, 64'h3000, 9'h004, 64'hAAAA_BBBB_CCCC_DDDD);
        tick();
        req_base = 64'h9990; req_wdata = 64'h0;   // pipeline changes inputs; must not be taken
        for (int i = 0; i < 5; i++) begin
            check("bp_mem_valid", 64'(mem_valid), 64'd1);
            check("bp_mem_addr", mem_addr, 64'h3004);
            check("bp_mem_wdata", mem_wdata, 64'hAAAA_BBBB_CCCC_DDDD);
            check("bp_mem_size", 64'(mem_size), 64'd2);
            check("bp_stall", 64'(stall), 64'd1);
            check("bp_req_ready", 64'(req_ready), 64'd0);
            tick();
        end
        req_valid = 1'b0;
        check("bp_still_issue", 64'(mem_valid), 64'd1);
        mem_ready = 1'b1;
        tick();
        check("bp_resp_valid", 64'(resp_valid), 64'd1);
        check("bp_resp_err", 64'(resp_err), 64'd0);
        tick();
        check("bp_idle", 64'(stall), 64'd0);
        $display("txn store backpressure addr=0x3004 done");

        // 5a) load timeout: 15 WAIT cycles with no data
        present(1'b1, 2'b11, 64'h5000, 9'h000, 64'h0);
        tick(); req_valid = 1'b0;
        tick();
        for (int i = 1; i < 15; i++) begin
            check("to_waiting", 64'(resp_valid), 64'd0);
            tick();
        end
        check("to_last_wait", 64'(resp_valid), 64'd0);
        check("to_last_stall", 64'(stall), 64'd1);
        tick();
        check("to_resp_valid", 64'(resp_valid), 64'd1);
        check("to_resp_err", 64'(resp_err), 64'd1);
        check("to_resp_rdata", resp_rdata, 64'd0);
        tick();
        $display("txn load timeout addr=0x5000 done");

        // 5b) data on the 15th WAIT cycle beats the timeout
        present(1'b1, 2'b11, 64'h5000, 9'h008, 64'h0);
        tick(); req_valid = 1'b0;
        tick();
        for (int i = 1; i < 15; i++) tick();
        check("tor_last_wait", 64'(resp_valid), 64'd0);
        mem_rvalid = 1'b1; mem_rdata = 64'h0123_4567_89AB_CDEF;
        tick(); mem_rvalid = 1'b0;
        check("tor_resp_valid", 64'(resp_valid), 64'd1);
        check("tor_resp_err", 64'(resp_err), 64'd0);
        check("tor_resp_rdata", resp_rdata, 64'h0123_4567_89AB_CDEF);
        tick();
        $display("txn load late data addr=0x5008 done");

        // 6a) address wrap below zero
        mem_ready = 1'b0;
        present(1'b0, 2'b00, 64'h4, 9'h100, 64'h55);
        tick(); req_valid = 1'b0;
        check("wrap_mem_addr", mem_addr, 64'hFFFF_FFFF_FFFF_FF04);
        mem_ready = 1'b1;
        tick();
        check("wrap_resp_valid", 64'(resp_valid), 64'd1);
        tick();
        $display("txn store wrap addr=0xffffffffffffff04 done");

        // 6b) reset while waiting for load data
        present(1'b1, 2'b11, 64'h6000, 9'h000, 64'h0);
        tick(); req_valid = 1'b0;
        tick();
        check("rw_in_wait", 64'(stall), 64'd1);
        reset = 1'b1;
        tick(); reset = 1'b0;
        check("rw_stall", 64'(stall), 64'd0);
        check("rw_req_ready", 64'(req_ready), 64'd1);
        check("rw_mem_valid", 64'(mem_valid), 64'd0);
        check("rw_resp_valid", 64'(resp_valid), 64'd0);
        mem_rvalid = 1'b1; mem_rdata = 64'hFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rw_stray_rvalid", 64'(resp_valid), 64'd0);
            check("rw_stray_idle", 64'(req_ready), 64'd1);
        end
        mem_rvalid = 1'b0;
        $display("txn reset in wait done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
